// File: rtl/layer_seq_ctrl.sv
// Frame sequencer for one convolution layer. It streams a feature map from a
// synchronous-read pixel memory into the layer input FIFO, honouring the
// FIFO's almost-full flag. It then counts the layer's output pulses to
// generate result-capture addresses. A frame ends on the expected output
// count or when the drain watchdog expires.
module layer_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CH_IN      = 3,
  parameter int WIDTH      = 112,
  parameter int IN_COUNT   = WIDTH * WIDTH,
  parameter int OUT_COUNT  = WIDTH * WIDTH,
  parameter int TIMEOUT    = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout_err,
  output logic                            rd_en,
  output logic [$clog2(IN_COUNT)-1:0]     rd_addr,
  input  logic [DATA_WIDTH*CH_IN-1:0]     rd_data,
  input  logic                            fifo_afull,
  output logic [DATA_WIDTH*CH_IN-1:0]     o_data,
  output logic                            wr_req,
  input  logic                            layer_valid,
  output logic                            out_we,
  output logic [$clog2(OUT_COUNT)-1:0]    out_addr
);

  localparam int RA_W = $clog2(IN_COUNT);
  localparam int OA_W = $clog2(OUT_COUNT);
  localparam int IC_W = $clog2(IN_COUNT + 1);
  localparam int OC_W = $clog2(OUT_COUNT + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [IC_W-1:0]   issued;
  logic [OC_W-1:0]   out_cnt;
  logic [WD_W-1:0]   wdog;
  logic              vld_p1;
  logic              feed_left;
  logic              last_out;
  logic              wd_expire;
  logic              accept_start;

  // Address increments hold at the last valid location instead of wrapping.
  function automatic logic [RA_W-1:0] sat_inc_rd(input logic [RA_W-1:0] v);
    return (v == RA_W'(IN_COUNT - 1)) ? v : v + RA_W'(1);
  endfunction

  function automatic logic [OA_W-1:0] sat_inc_out(input logic [OA_W-1:0] v);
    return (v == OA_W'(OUT_COUNT - 1)) ? v : v + OA_W'(1);
  endfunction

  assign busy         = (state == FEED) || (state == DRAIN);
  assign done         = (state == DONE);
  assign accept_start = (state == IDLE) && start;
  assign feed_left    = (issued < IC_W'(IN_COUNT));
  assign out_we       = layer_valid && busy;
  assign last_out     = out_we && (out_cnt == OC_W'(OUT_COUNT - 1));
  assign wd_expire    = (state == DRAIN) && !layer_valid && (wdog == WD_W'(TIMEOUT - 1));
  assign rd_en        = (state == FEED) && !fifo_afull && feed_left;
  // Stage p1: read data returns one cycle after rd_en; a word still in flight
  // when the frame ends early is dropped rather than pushed into the FIFO.
  assign wr_req       = vld_p1 && (state == FEED);
  assign o_data       = rd_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; reaching the output count wins over feed/drain progress.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FEED;
      FEED:    if (last_out) state_nxt = DONE;
               else if (!feed_left) state_nxt = DRAIN;
      DRAIN:   if (last_out || wd_expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read/issue counters, output addressing, watchdog and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      rd_addr     <= '0;
      issued      <= '0;
      out_addr    <= '0;
      out_cnt     <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (accept_start) begin
        rd_addr     <= '0;
        issued      <= '0;
        out_addr    <= '0;
        out_cnt     <= '0;
        wdog        <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (rd_en) begin
          rd_addr <= sat_inc_rd(rd_addr);
          issued  <= issued + IC_W'(1);
        end
        if (out_we) begin
          out_addr <= sat_inc_out(out_addr);
          out_cnt  <= out_cnt + OC_W'(1);
        end
        if (state == DRAIN) wdog <= layer_valid ? '0 : wdog + WD_W'(1);
        if (wd_expire) timeout_err <= 1'b1;
      end
    end
  end

endmodule
